fp_exception_pipe: RTL and testbench
====================================

Name: fp_exception_pipe

Overview:
Pipelined special-case and exception analyser for the real-number multiply/divide datapath, successor to the single-cycle combinational error check. Classifies both IEEE-754 operands, decides invalid / divide-by-zero / special-result for MUL and DIV, and carries the decision through a parametrised-depth valid/ready pipeline in lockstep with the arithmetic core. Accumulates sticky exception flags and a saturating error counter for status readback.

Parameters:
IS_DOUBLE, 0, 0 = binary32 (exp 8, mant 23), 1 = binary64 (exp 11, mant 52)
WIDTH, IS_DOUBLE ? 64 : 32, operand width; derived, not overridden
STAGES, 2, pipeline depth (latency in cycles, >= 1)
CNT_W, 8, error counter width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  pipeline can accept
op1  input  WIDTH  first operand (multiplicand / dividend)
op2  input  WIDTH  second operand (multiplier / divisor)
opcode  input  2  00 NOP, 01 MUL, 10 DIV, 11 reserved
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
out_invalid  output  1  invalid operation
out_divzero  output  1  divide by zero
out_illegal  output  1  reserved opcode used
out_special  output  1  out_special_val replaces datapath result
out_special_val  output  WIDTH  canonical special result
clr_sticky  input  1  synchronous clear of sticky flags and counter
sticky_invalid  output  1  sticky invalid
sticky_divzero  output  1  sticky divide by zero
err_count  output  CNT_W  saturating count of errored results

Behaviour:
- Reset: one clock, clk; asynchronous, active-low reset rst_n. While rst_n is low, all stage valids, every out_* flag, out_special_val, both sticky flags and err_count are 0. Reset mid-operation drops all in-flight entries.
- Classification: exp all-ones, mant != 0 -> NaN; exp all-ones, mant 0 -> inf; exp 0, mant 0 -> zero; exp 0, mant != 0 -> denorm; otherwise norm. Denorms count as finite nonzero. Result sign s = sign1 ^ sign2.
- NOP: all flags 0, special 0.
- Reserved opcode 11: out_illegal 1, other flags 0, special 0.
- MUL:
  - invalid if either operand is NaN, or zero x inf (either order).
  - Else if either operand is inf -> special, signed inf.
  - Else if either operand is zero -> special, signed zero.
- DIV:
  - invalid if either operand is NaN, 0/0, or inf/inf.
  - divzero if op2 is zero and op1 is finite nonzero -> special, signed inf.
  - inf/finite -> signed inf.
  - finite/inf -> signed zero.
  - 0/(finite nonzero) -> signed zero.
- Invalid always gives special 1 with the canonical qNaN: 0x7FC00000 or 0x7FF8000000000000. Inf = s, exp all-ones, mant 0. Zero = s, all other bits 0. out_special_val is 0 when out_special is 0.
- Pipeline:
  - Classification is registered in stage 0; the decision is propagated through STAGES registers.
  - Latency is exactly STAGES cycles with no stall.
  - Each stage loads when empty or when its successor advances, so bubbles collapse.
  - in_ready = stage 0 empty or advancing.
  - Transfer occurs on valid & ready on both sides.
  - With out_valid high and out_ready low, out_* hold stable. No loss or duplication; order is preserved.
  - Full throughput is one op per cycle when out_ready is held high.
- Sticky and counter:
  - On an output handshake with out_invalid, sticky_invalid is set; with out_divzero, sticky_divzero is set.
  - err_count increments by 1 per handshaken result with invalid | divzero | illegal. It saturates at all-ones (no wrap).
  - clr_sticky clears flags and counter next edge. If an event handshakes in the same cycle, the event wins: the flag reads 1 and the count reads 1.

Test Plan:
- Single MUL, STAGES=2: 0x3F800000 x 0x40000000 -> out_valid exactly 2 cycles later; all flags 0, special 0.
- MUL 0x00000000 x 0xFF800000 -> invalid, special, value 0x7FC00000, sticky_invalid 1, err_count 1. Then 0x80000000 x 0x3F800000 -> special 0x80000000, no flags.
- DIV 0x40400000 / 0x80000000 -> divzero, special 0xFF800000. 0x7F800000 / 0x7F800000 -> invalid 0x7FC00000. 0x3F800000 / 0x7F800000 -> special 0x00000000.
- Backpressure: 8 back-to-back ops with out_ready low for 5 cycles mid-stream -> in_ready drops once full, outputs held stable, all 8 emerge in order, none lost.
- 260 invalid ops with CNT_W=8 -> err_count saturates at 255. Then clr_sticky coincident with an invalid handshake -> err_count 1, sticky_invalid 1.
- IS_DOUBLE=1, opcode 11, and mid-stream reset: opcode 11 -> out_illegal 1. DIV 0 / 0 -> 0x7FF8000000000000. rst_n low for half a cycle mid-stream -> out_valid and all status outputs read 0 immediately.

Source files
------------

// File: rtl/fp_exception_pipe.sv
// rtl/fp_exception_pipe.sv - pipelined IEEE-754 MUL/DIV special-case and exception analyser
// Operands are classified into stage 0; the decision then rides a valid/ready pipe of STAGES registers.
module fp_exception_pipe #(
    parameter int IS_DOUBLE = 0,
    localparam int WIDTH    = (IS_DOUBLE != 0) ? 64 : 32,
    parameter int STAGES    = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [1:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_invalid,
    output logic             out_divzero,
    output logic             out_illegal,
    output logic             out_special,
    output logic [WIDTH-1:0] out_special_val,
    input  logic             clr_sticky,
    output logic             sticky_invalid,
    output logic             sticky_divzero,
    output logic [CNT_W-1:0] err_count
);

    localparam int EXP_W  = (IS_DOUBLE != 0) ? 11 : 8;
    localparam int MANT_W = WIDTH - 1 - EXP_W;
    localparam logic [WIDTH-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        CL_ZERO   = 3'd0,
        CL_DENORM = 3'd1,
        CL_NORM   = 3'd2,
        CL_INF    = 3'd3,
        CL_NAN    = 3'd4
    } cls_t;

    typedef struct packed {
        cls_t       c1;
        cls_t       c2;
        logic       sign;
        logic [1:0] opcode;
    } cls_rec_t;

    typedef struct packed {
        logic             invalid;
        logic             divzero;
        logic             illegal;
        logic             special;
        logic [WIDTH-1:0] val;
    } dec_t;

    function automatic cls_t classify(input logic [WIDTH-1:0] x);
        logic [EXP_W-1:0]  e;
        logic [MANT_W-1:0] m;
        cls_t              c;
        e = x[WIDTH-2 -: EXP_W];
        m = x[MANT_W-1:0];
        if (&e)
            c = (|m) ? CL_NAN : CL_INF;
        else if (e == '0)
            c = (|m) ? CL_DENORM : CL_ZERO;
        else
            c = CL_NORM;
        return c;
    endfunction

    function automatic dec_t decide(input cls_rec_t r);
        dec_t             d;
        logic             nan_any, inf1, inf2, zero1, zero2, fin1;
        logic [WIDTH-1:0] inf_v, zero_v;
        d       = '0;
        nan_any = (r.c1 == CL_NAN) | (r.c2 == CL_NAN);
        inf1    = (r.c1 == CL_INF);
        inf2    = (r.c2 == CL_INF);
        zero1   = (r.c1 == CL_ZERO);
        zero2   = (r.c2 == CL_ZERO);
        fin1    = (r.c1 == CL_DENORM) | (r.c1 == CL_NORM);
        inf_v   = {r.sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        zero_v  = {r.sign, {(WIDTH-1){1'b0}}};
        case (r.opcode)
            2'b01: begin
                if (nan_any | (zero1 & inf2) | (inf1 & zero2)) begin
                    d.invalid = 1'b1;
                end else if (inf1 | inf2) begin
                    d.special = 1'b1;
                    d.val     = inf_v;
                end else if (zero1 | zero2) begin
                    d.special = 1'b1;
                    d.val     = zero_v;
                end
            end
            2'b10: begin
                if (nan_any | (zero1 & zero2) | (inf1 & inf2)) begin
                    d.invalid = 1'b1;
                end else if (zero2 & fin1) begin
                    d.divzero = 1'b1;
                    d.special = 1'b1;
                    d.val     = inf_v;
                end else if (inf1) begin
                    d.special = 1'b1;
                    d.val     = inf_v;
                end else if (inf2 | zero1) begin
                    d.special = 1'b1;
                    d.val     = zero_v;
                end
            end
            2'b11: d.illegal = 1'b1;
            default: ;
        endcase
        if (d.invalid) begin
            d.special = 1'b1;
            d.val     = QNAN;
        end
        return d;
    endfunction

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] vin;
    cls_rec_t          s0_q;
    dec_t              out_dec;

    // A stage may load if any stage from it to the output is empty, or the output is taken.
    always_comb begin
        logic acc;
        acc  = out_ready;
        load = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc     = acc | ~vld_q[i];
            load[i] = acc;
        end
    end

    assign vin      = (vld_q << 1) | STAGES'(in_valid);
    assign in_ready = load[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            s0_q  <= '0;
        end else begin
            vld_q <= (load & vin) | (~load & vld_q);
            if (load[0] && in_valid)
                s0_q <= '{c1: classify(op1), c2: classify(op2),
                          sign: op1[WIDTH-1] ^ op2[WIDTH-1], opcode: opcode};
        end
    end

    generate
        if (STAGES > 1) begin : g_dec_pipe
            dec_t dec_q [1:STAGES-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 1; i < STAGES; i++)
                        dec_q[i] <= '0;
                end else begin
                    if (load[1] && vld_q[0])
                        dec_q[1] <= decide(s0_q);
                    for (int i = 2; i < STAGES; i++)
                        if (load[i] && vld_q[i-1])
                            dec_q[i] <= dec_q[i-1];
                end
            end

            assign out_dec = dec_q[STAGES-1];
        end else begin : g_dec_direct
            assign out_dec = decide(s0_q);
        end
    endgenerate

    assign out_valid       = vld_q[STAGES-1];
    assign out_invalid     = out_valid & out_dec.invalid;
    assign out_divzero     = out_valid & out_dec.divzero;
    assign out_illegal     = out_valid & out_dec.illegal;
    assign out_special     = out_valid & out_dec.special;
    assign out_special_val = out_valid ? out_dec.val : '0;

    logic out_hs;
    logic err_evt;
    assign out_hs  = out_valid & out_ready;
    assign err_evt = out_hs & (out_invalid | out_divzero | out_illegal);

    // A handshaken event in the clear cycle survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_invalid <= 1'b0;
            sticky_divzero <= 1'b0;
            err_count      <= '0;
        end else if (clr_sticky) begin
            sticky_invalid <= out_hs & out_invalid;
            sticky_divzero <= out_hs & out_divzero;
            err_count      <= err_evt ? CNT_W'(1) : '0;
        end else begin
            if (out_hs & out_invalid)
                sticky_invalid <= 1'b1;
            if (out_hs & out_divzero)
                sticky_divzero <= 1'b1;
            if (err_evt && !(&err_count))
                err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_exception_pipe.sv
// tb/tb_fp_exception_pipe.sv - scoreboard bench for fp_exception_pipe (binary32 and binary64 instances)
module tb_fp_exception_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        s_in_valid = 0, s_in_ready, s_out_valid, s_out_ready = 1, s_clr = 0;
    logic [31:0] s_op1 = 0, s_op2 = 0, s_val;
    logic [1:0]  s_opcode = 0;
    logic        s_inv, s_dz, s_ill, s_sp, s_si, s_sd;
    logic [7:0]  s_cnt;

    logic        d_in_valid = 0, d_in_ready, d_out_valid, d_out_ready = 1, d_clr = 0;
    logic [63:0] d_op1 = 0, d_op2 = 0, d_val;
    logic [1:0]  d_opcode = 0;
    logic        d_inv, d_dz, d_ill, d_sp, d_si, d_sd;
    logic [7:0]  d_cnt;

    fp_exception_pipe #(.IS_DOUBLE(0), .STAGES(2), .CNT_W(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .op1(s_op1), .op2(s_op2), .opcode(s_opcode), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_invalid(s_inv), .out_divzero(s_dz),
        .out_illegal(s_ill), .out_special(s_sp), .out_special_val(s_val),
        .clr_sticky(s_clr), .sticky_invalid(s_si), .sticky_divzero(s_sd), .err_count(s_cnt)
    );

    fp_exception_pipe #(.IS_DOUBLE(1), .STAGES(3), .CNT_W(8)) dut_d (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .op1(d_op1), .op2(d_op2), .opcode(d_opcode), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .out_invalid(d_inv), .out_divzero(d_dz),
        .out_illegal(d_ill), .out_special(d_sp), .out_special_val(d_val),
        .clr_sticky(d_clr), .sticky_invalid(d_si), .sticky_divzero(d_sd), .err_count(d_cnt)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: 0 zero, 1 finite nonzero, 2 inf, 3 NaN.
    function automatic int cls(input logic [63:0] x, input int ew, input int mw);
        logic [63:0] e, m, emask;
        emask = (64'd1 << ew) - 1;
        e = (x >> mw) & emask;
        m = x & ((64'd1 << mw) - 1);
        if (e == emask) return (m != 0) ? 3 : 2;
        if (e == 0 && m == 0) return 0;
        return 1;
    endfunction

    // Result packed as {invalid, divzero, illegal, special, value}.
    function automatic logic [67:0] ref_model(input bit dbl, input logic [63:0] a,
                                              input logic [63:0] b, input logic [1:0] op);
        int ew, mw, w, ca, cb;
        logic [63:0] emask, inf_v, zero_v, qnan;
        logic s;
        ew = dbl ? 11 : 8;
        mw = dbl ? 52 : 23;
        w  = dbl ? 64 : 32;
        emask  = (64'd1 << ew) - 1;
        s      = a[w-1] ^ b[w-1];
        ca     = cls(a, ew, mw);
        cb     = cls(b, ew, mw);
        zero_v = {63'd0, s} << (w - 1);
        inf_v  = zero_v | (emask << mw);
        qnan   = dbl ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
        case (op)
            2'd1: begin
                if (ca == 3 || cb == 3 || (ca == 0 && cb == 2) || (ca == 2 && cb == 0))
                    return {4'b1001, qnan};
                if (ca == 2 || cb == 2) return {4'b0001, inf_v};
                if (ca == 0 || cb == 0) return {4'b0001, zero_v};
                return '0;
            end
            2'd2: begin
                if (ca == 3 || cb == 3 || (ca == 0 && cb == 0) || (ca == 2 && cb == 2))
                    return {4'b1001, qnan};
                if (cb == 0 && ca == 1) return {4'b0101, inf_v};
                if (ca == 2) return {4'b0001, inf_v};
                if (cb == 2 || ca == 0) return {4'b0001, zero_v};
                return '0;
            end
            2'd3: return {4'b0010, 64'd0};
            default: return '0;
        endcase
    endfunction

    function automatic logic [63:0] rand_operand(input bit dbl);
        int ew, mw, k;
        logic [63:0] emask, m, e, s;
        ew = dbl ? 11 : 8;
        mw = dbl ? 52 : 23;
        emask = (64'd1 << ew) - 1;
        m = {$urandom, $urandom} & ((64'd1 << mw) - 1);
        s = 64'($urandom_range(0, 1)) << (dbl ? 63 : 31);
        k = $urandom_range(0, 5);
        case (k)
            0: begin e = 0; m = 0; end
            1: begin e = 0; m = m | 64'd1; end
            4: begin e = emask; m = 0; end
            5: begin e = emask; m = m | 64'd1; end
            default: e = 64'($urandom_range(1, int'(emask) - 1));
        endcase
        return s | (e << mw) | m;
    endfunction

    logic [67:0] q_s[$];
    logic [67:0] q_d[$];
    int ms_cnt = 0, md_cnt = 0;
    bit ms_si = 0, ms_sd = 0, md_si = 0, md_sd = 0;
    bit s_held = 0, d_held = 0;
    logic [67:0] s_held_val, d_held_val;

    always @(negedge clk) begin : mon_s
        logic [67:0] act, exp;
        bit hs, e_inv, e_dz, e_err;
        #2;
        if (rst_n) begin
            act = {s_inv, s_dz, s_ill, s_sp, 32'h0, s_val};
            if (s_held) begin
                chk("s_hold_valid", 68'(s_out_valid), 68'd1);
                chk("s_hold_data", act, s_held_val);
            end
            chk("s_err_count", 68'(s_cnt), 68'(ms_cnt));
            chk("s_sticky", {66'd0, s_si, s_sd}, {66'd0, ms_si, ms_sd});
            hs = s_out_valid && s_out_ready;
            e_inv = 0; e_dz = 0; e_err = 0;
            if (hs) begin
                if (q_s.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL s_unexpected_output actual=%h expected=none", act);
                end else begin
                    exp = q_s.pop_front();
                    chk("s_result", act, exp);
                    e_inv = exp[67]; e_dz = exp[66]; e_err = exp[67] | exp[66] | exp[65];
                end
            end
            if (s_clr) begin
                ms_si = e_inv; ms_sd = e_dz; ms_cnt = e_err ? 1 : 0;
            end else begin
                ms_si = ms_si | e_inv; ms_sd = ms_sd | e_dz;
                if (e_err && ms_cnt < 255) ms_cnt++;
            end
            s_held = s_out_valid && !s_out_ready;
            s_held_val = act;
        end
    end

    always @(negedge clk) begin : mon_d
        logic [67:0] act, exp;
        bit hs, e_inv, e_dz, e_err;
        #2;
        if (rst_n) begin
            act = {d_inv, d_dz, d_ill, d_sp, d_val};
            if (d_held) begin
                chk("d_hold_valid", 68'(d_out_valid), 68'd1);
                chk("d_hold_data", act, d_held_val);
            end
            chk("d_err_count", 68'(d_cnt), 68'(md_cnt));
            chk("d_sticky", {66'd0, d_si, d_sd}, {66'd0, md_si, md_sd});
            hs = d_out_valid && d_out_ready;
            e_inv = 0; e_dz = 0; e_err = 0;
            if (hs) begin
                if (q_d.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL d_unexpected_output actual=%h expected=none", act);
                end else begin
                    exp = q_d.pop_front();
                    chk("d_result", act, exp);
                    e_inv = exp[67]; e_dz = exp[66]; e_err = exp[67] | exp[66] | exp[65];
                end
            end
            if (d_clr) begin
                md_si = e_inv; md_sd = e_dz; md_cnt = e_err ? 1 : 0;
            end else begin
                md_si = md_si | e_inv; md_sd = md_sd | e_dz;
                if (e_err && md_cnt < 255) md_cnt++;
            end
            d_held = d_out_valid && !d_out_ready;
            d_held_val = act;
        end
    end

    task automatic issue(input bit dbl, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] op);
        int n;
        n = 0;
        @(negedge clk);
        if (dbl) begin
            d_op1 = a; d_op2 = b; d_opcode = op; d_in_valid = 1;
        end else begin
            s_op1 = a[31:0]; s_op2 = b[31:0]; s_opcode = op; s_in_valid = 1;
        end
        #1;
        while (!(dbl ? d_in_ready : s_in_ready) && n < 100) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (!(dbl ? d_in_ready : s_in_ready)) begin
            failures++;
            $display("FAIL issue_timeout actual=in_ready_low expected=in_ready_high");
        end else begin
            if (dbl) q_d.push_back(ref_model(1, a, b, op));
            else     q_s.push_back(ref_model(0, a & 64'hFFFF_FFFF, b & 64'hFFFF_FFFF, op));
            @(posedge clk);
            #1;
        end
        s_in_valid = 0;
        d_in_valid = 0;
    endtask

    task automatic drain(input bit dbl);
        int n;
        n = 0;
        while ((dbl ? q_d.size() : q_s.size()) != 0 && n < 500) begin
            @(negedge clk); n++;
        end
        chk(dbl ? "d_drain_left" : "s_drain_left", 68'(dbl ? q_d.size() : q_s.size()), 68'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit done;
        bit saw_full;
        int n;

        #1;
        chk("rst_s_outputs", {s_out_valid, s_inv, s_dz, s_ill, s_sp, s_si, s_sd, s_cnt, s_val}, '0);
        chk("rst_d_outputs", {d_out_valid, d_inv, d_dz, d_ill, d_sp, d_si, d_sd, d_cnt}, '0);
        chk("rst_d_val", 68'(d_val), 68'd0);
        @(negedge clk);
        rst_n = 1;

        issue(0, 64'h3F80_0000, 64'h4000_0000, 2'b01);
        chk("lat_not_early", 68'(s_out_valid), 68'd0);
        @(posedge clk); #1;
        chk("lat_on_time", 68'(s_out_valid), 68'd1);
        issue(0, 64'h0000_0000, 64'hFF80_0000, 2'b01);
        drain(0);
        chk("tp_sticky_invalid", 68'(s_si), 68'd1);
        chk("tp_err_count_1", 68'(s_cnt), 68'd1);
        issue(0, 64'h8000_0000, 64'h3F80_0000, 2'b01);
        issue(0, 64'h4040_0000, 64'h8000_0000, 2'b10);
        issue(0, 64'h7F80_0000, 64'h7F80_0000, 2'b10);
        issue(0, 64'h3F80_0000, 64'h7F80_0000, 2'b10);
        drain(0);
        chk("tp_sticky_divzero", 68'(s_sd), 68'd1);

        saw_full = 0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    issue(0, rand_operand(0), rand_operand(0), 2'($urandom_range(0, 3)));
            end
            begin
                repeat (3) @(negedge clk);
                s_out_ready = 0;
                repeat (5) @(negedge clk);
                s_out_ready = 1;
            end
            begin
                repeat (12) begin
                    @(negedge clk); #1;
                    if (!s_in_ready) saw_full = 1;
                end
            end
        join
        chk("bp_in_ready_dropped", 68'(saw_full), 68'd1);
        drain(0);

        done = 0;
        fork
            begin
                for (int i = 0; i < 200; i++)
                    issue(0, rand_operand(0), rand_operand(0), 2'($urandom_range(0, 3)));
                done = 1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    s_out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        s_out_ready = 1;
        drain(0);

        for (int i = 0; i < 260; i++)
            issue(0, 64'h7FC0_0001, rand_operand(0), 2'b01);
        drain(0);
        chk("err_saturated", 68'(s_cnt), 68'd255);

        s_out_ready = 0;
        issue(0, 64'h7F80_0001, 64'h3F80_0000, 2'b01);
        n = 0;
        while (!s_out_valid && n < 10) begin
            @(posedge clk); #1; n++;
        end
        @(negedge clk);
        s_clr = 1;
        s_out_ready = 1;
        @(posedge clk); #1;
        s_clr = 0;
        chk("clr_event_wins_count", 68'(s_cnt), 68'd1);
        chk("clr_event_wins_sticky", {66'd0, s_si, s_sd}, {66'd0, 1'b1, 1'b0});

        issue(1, 64'd0, 64'd0, 2'b11);
        issue(1, 64'd0, 64'd0, 2'b10);
        drain(1);
        chk("d_illegal_counted", 68'(d_cnt), 68'd2);
        done = 0;
        fork
            begin
                for (int i = 0; i < 60; i++)
                    issue(1, rand_operand(1), rand_operand(1), 2'($urandom_range(0, 3)));
                done = 1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    d_out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        d_out_ready = 1;
        drain(1);

        d_out_ready = 0;
        issue(1, 64'h7FF0_0000_0000_0000, 64'd0, 2'b01);
        issue(1, 64'h3FF0_0000_0000_0000, 64'd0, 2'b10);
        @(posedge clk); #1;
        rst_n = 0;
        q_s.delete(); q_d.delete();
        ms_cnt = 0; md_cnt = 0; ms_si = 0; ms_sd = 0; md_si = 0; md_sd = 0;
        s_held = 0; d_held = 0;
        #1;
        chk("mid_rst_d_status", {d_out_valid, d_inv, d_dz, d_ill, d_sp, d_si, d_sd, d_cnt}, '0);
        chk("mid_rst_d_val", 68'(d_val), 68'd0);
        chk("mid_rst_s_status", {s_out_valid, s_si, s_sd, s_cnt}, '0);
        @(negedge clk);
        rst_n = 1;
        d_out_ready = 1;
        @(posedge clk); #1;
        chk("post_rst_no_stale", 68'(d_out_valid), 68'd0);
        issue(1, 64'h8000_0000_0000_0000, 64'h7FF0_0000_0000_0000, 2'b01);
        drain(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
